// File: rtl/cc_ben_pkg.sv
// Shared NZP condition-code types and constants for the CC/BEN unit.
// Pure declarations; no logic of its own.
package cc_ben_pkg;

  typedef logic [2:0] nzp_t;

  localparam nzp_t NZP_N = 3'b100;
  localparam nzp_t NZP_Z = 3'b010;
  localparam nzp_t NZP_P = 3'b001;

  function automatic logic is_onehot3(input nzp_t v);
    return (v == NZP_N) || (v == NZP_Z) || (v == NZP_P);
  endfunction

endpackage

// File: rtl/cc_encode.sv
// Bus value to one-hot NZP encoder; MODE=1 treats the value as unsigned.
// Combinational, zero latency, no flow control.
module cc_encode
  import cc_ben_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] din,
  input  logic              mode,
  output nzp_t              nzp
);

  always_comb begin
    nzp = NZP_P;
    if (din == '0) begin
      nzp = NZP_Z;
    end else if (!mode && din[DATA_W-1]) begin
      nzp = NZP_N;
    end
  end

endmodule

// File: rtl/cc_ben_unit.sv
// Multi-context NZP registers with registered BEN, staleness flag and optional
// branch statistics (BRANCH_STATS_EN). BEN latency 1 cycle; no backpressure.
module cc_ben_unit
  import cc_ben_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_CTX = 2,
  parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  parameter int STAT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DIN,
  input  logic              MODE,
  input  logic [CTX_W-1:0]  CTX_SEL,
  input  logic              LD_CC,
  input  logic              LD_CC_PSR,
  input  logic [2:0]        PSR_CC_IN,
  input  logic [2:0]        IR_Slice,
  input  logic              LD_BEN,
  input  logic              CLR_STATS,
  output logic [2:0]        NZP_OUT,
  output logic              BEN_OUT,
  output logic              BEN_VALID,
  output logic              CC_INIT,
  output logic [STAT_W-1:0] BR_EVAL_CNT,
  output logic [STAT_W-1:0] BR_TAKEN_CNT
);

  // Array is sized to the full select range so any CTX_SEL indexes safely;
  // slots at or above NUM_CTX are never written.
  localparam int              NSLOT     = 1 << CTX_W;
  localparam logic [CTX_W:0]  NUM_CTX_L = (CTX_W + 1)'(NUM_CTX);

  nzp_t             cc_q [NSLOT];
  logic [NSLOT-1:0] init_q;
  logic [CTX_W-1:0] ben_ctx_q;

  logic sel_ok;
  logic wr_en;
  logic ben_next;
  nzp_t enc_nzp;
  nzp_t cur_cc;
  nzp_t wr_val;

  cc_encode #(
    .DATA_W(DATA_W)
  ) u_enc (
    .din  (DIN),
    .mode (MODE),
    .nzp  (enc_nzp)
  );

  assign sel_ok   = {1'b0, CTX_SEL} < NUM_CTX_L;
  assign cur_cc   = sel_ok ? cc_q[CTX_SEL] : 3'b000;
  assign wr_en    = sel_ok && (LD_CC || LD_CC_PSR);
  assign wr_val   = LD_CC_PSR ? (is_onehot3(PSR_CC_IN) ? PSR_CC_IN : NZP_Z) : enc_nzp;
  assign ben_next = |(cur_cc & IR_Slice);

  assign NZP_OUT = cur_cc;
  assign CC_INIT = sel_ok && init_q[CTX_SEL];

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        cc_q[i] <= NZP_Z;
      end
      init_q    <= '0;
      ben_ctx_q <= '0;
      BEN_OUT   <= 1'b0;
      BEN_VALID <= 1'b0;
    end else begin
      if (wr_en) begin
        cc_q[CTX_SEL]   <= wr_val;
        init_q[CTX_SEL] <= 1'b1;
      end
      // A same-cycle write to the evaluated context makes the new BEN stale at birth.
      if (LD_BEN) begin
        BEN_OUT   <= ben_next;
        BEN_VALID <= !wr_en;
        ben_ctx_q <= CTX_SEL;
      end else if (wr_en && (CTX_SEL == ben_ctx_q)) begin
        BEN_VALID <= 1'b0;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] eval_q;
  logic [STAT_W-1:0] taken_q;

  always_ff @(posedge Clk) begin
    if (!Reset || CLR_STATS) begin
      eval_q  <= '0;
      taken_q <= '0;
    end else if (LD_BEN) begin
      if (eval_q != '1) begin
        eval_q <= eval_q + 1'b1;
      end
      if (ben_next && (taken_q != '1)) begin
        taken_q <= taken_q + 1'b1;
      end
    end
  end

  assign BR_EVAL_CNT  = eval_q;
  assign BR_TAKEN_CNT = taken_q;
`else
  logic stats_unused;
  assign stats_unused = CLR_STATS;
  assign BR_EVAL_CNT  = '0;
  assign BR_TAKEN_CNT = '0;
`endif

endmodule

// File: tb/tb_cc_ben_unit.sv
// Scoreboard bench for cc_ben_unit: directed plan followed by random traffic.
module tb_cc_ben_unit;

  localparam int DATA_W  = 16;
  localparam int NUM_CTX = 3;
  localparam int CTX_W   = 2;
  localparam int STAT_W  = 4;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic [DATA_W-1:0] DIN = '0;
  logic              MODE = 1'b0;
  logic [CTX_W-1:0]  CTX_SEL = '0;
  logic              LD_CC = 1'b0;
  logic              LD_CC_PSR = 1'b0;
  logic [2:0]        PSR_CC_IN = 3'b000;
  logic [2:0]        IR_Slice = 3'b000;
  logic              LD_BEN = 1'b0;
  logic              CLR_STATS = 1'b0;
  logic [2:0]        NZP_OUT;
  logic              BEN_OUT;
  logic              BEN_VALID;
  logic              CC_INIT;
  logic [STAT_W-1:0] BR_EVAL_CNT;
  logic [STAT_W-1:0] BR_TAKEN_CNT;

  cc_ben_unit #(
    .DATA_W (DATA_W),
    .NUM_CTX(NUM_CTX),
    .CTX_W  (CTX_W),
    .STAT_W (STAT_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .DIN         (DIN),
    .MODE        (MODE),
    .CTX_SEL     (CTX_SEL),
    .LD_CC       (LD_CC),
    .LD_CC_PSR   (LD_CC_PSR),
    .PSR_CC_IN   (PSR_CC_IN),
    .IR_Slice    (IR_Slice),
    .LD_BEN      (LD_BEN),
    .CLR_STATS   (CLR_STATS),
    .NZP_OUT     (NZP_OUT),
    .BEN_OUT     (BEN_OUT),
    .BEN_VALID   (BEN_VALID),
    .CC_INIT     (CC_INIT),
    .BR_EVAL_CNT (BR_EVAL_CNT),
    .BR_TAKEN_CNT(BR_TAKEN_CNT)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]        nzp;
    logic              ben;
    logic              vld;
    logic              init;
    logic [STAT_W-1:0] ev;
    logic [STAT_W-1:0] tk;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [2:0]        m_cc   [4];
  logic              m_init [4];
  logic              m_ben;
  logic              m_vld;
  logic [1:0]        m_bctx;
  logic [STAT_W-1:0] m_ev;
  logic [STAT_W-1:0] m_tk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] m_enc(input logic [15:0] d, input logic md);
    if (d == 16'h0000) return 3'b010;
    if (!md && d[15]) return 3'b100;
    return 3'b001;
  endfunction

  task automatic step(input logic rst, input logic ld, input logic lp, input logic lb,
                      input logic clr, input logic [15:0] din, input logic md,
                      input logic [1:0] ctx, input logic [2:0] psr, input logic [2:0] ir);
    exp_t       e;
    exp_t       o;
    logic       ok;
    logic       wr;
    logic       tb_ben;
    logic [2:0] old;
    Reset = rst; LD_CC = ld; LD_CC_PSR = lp; LD_BEN = lb; CLR_STATS = clr;
    DIN = din; MODE = md; CTX_SEL = ctx; PSR_CC_IN = psr; IR_Slice = ir;
    ok = (int'(ctx) < NUM_CTX);
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        m_cc[i] = 3'b010;
        m_init[i] = 1'b0;
      end
      m_ben = 1'b0; m_vld = 1'b0; m_bctx = 2'd0; m_ev = '0; m_tk = '0;
    end else begin
      old = ok ? m_cc[ctx] : 3'b000;
      wr  = ok && (ld || lp);
      tb_ben = (old & ir) != 3'b000;
`ifdef BRANCH_STATS_EN
      if (clr) begin
        m_ev = '0;
        m_tk = '0;
      end else if (lb) begin
        if (m_ev != 4'hF) m_ev = m_ev + 4'd1;
        if (tb_ben && m_tk != 4'hF) m_tk = m_tk + 4'd1;
      end
`endif
      if (lb) begin
        m_ben = tb_ben; m_vld = !wr; m_bctx = ctx;
      end else if (wr && ctx == m_bctx) begin
        m_vld = 1'b0;
      end
      if (wr) begin
        if (lp) m_cc[ctx] = (psr == 3'b100 || psr == 3'b010 || psr == 3'b001) ? psr : 3'b010;
        else    m_cc[ctx] = m_enc(din, md);
        m_init[ctx] = 1'b1;
      end
    end
    e.nzp  = ok ? m_cc[ctx] : 3'b000;
    e.init = ok ? m_init[ctx] : 1'b0;
    e.ben  = m_ben;
    e.vld  = m_vld;
    e.ev   = m_ev;
    e.tk   = m_tk;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    o = sb.pop_front();
    chk("nzp",   32'(NZP_OUT),      32'(o.nzp));
    chk("ben",   32'(BEN_OUT),      32'(o.ben));
    chk("vld",   32'(BEN_VALID),    32'(o.vld));
    chk("init",  32'(CC_INIT),      32'(o.init));
    chk("eval",  32'(BR_EVAL_CNT),  32'(o.ev));
    chk("taken", 32'(BR_TAKEN_CNT), 32'(o.tk));
  endtask

  task automatic idle(input logic [1:0] ctx, input logic [2:0] ir);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, ctx, 3'b000, ir);
  endtask

  task automatic ldcc(input logic [1:0] ctx, input logic [15:0] din, input logic md);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, din, md, ctx, 3'b000, 3'b000);
  endtask

  task automatic ldben(input logic [1:0] ctx, input logic [2:0] ir);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, ctx, 3'b000, ir);
  endtask

  initial begin
    // Power-on reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 3'b000, 3'b000);
    chk("rst_nzp", 32'(NZP_OUT), 32'h2);
    chk("rst_vld", 32'(BEN_VALID), 32'h0);
    chk("rst_init", 32'(CC_INIT), 32'h0);

    // Encoding
    ldcc(2'd0, 16'h8001, 1'b0); chk("enc_neg", 32'(NZP_OUT), 32'h4);
    chk("init_set", 32'(CC_INIT), 32'h1);
    ldcc(2'd0, 16'h0000, 1'b0); chk("enc_zero", 32'(NZP_OUT), 32'h2);
    ldcc(2'd0, 16'h7FFF, 1'b0); chk("enc_pos", 32'(NZP_OUT), 32'h1);
    ldcc(2'd0, 16'h8001, 1'b1); chk("enc_uns", 32'(NZP_OUT), 32'h1);

    // Context independence
    ldcc(2'd0, 16'h8000, 1'b0);
    ldcc(2'd1, 16'h0001, 1'b0);
    ldben(2'd1, 3'b100); chk("ctx1_ben", 32'(BEN_OUT), 32'h0);
    ldben(2'd0, 3'b100); chk("ctx0_ben", 32'(BEN_OUT), 32'h1);
    chk("ctx0_vld", 32'(BEN_VALID), 32'h1);

    // Staleness
    ldcc(2'd1, 16'h0000, 1'b0); chk("other_ctx_vld", 32'(BEN_VALID), 32'h1);
    ldcc(2'd0, 16'h8000, 1'b0); chk("stale_vld", 32'(BEN_VALID), 32'h0);
    ldben(2'd0, 3'b100);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 2'd0, 3'b000, 3'b001);
    chk("simul_ben", 32'(BEN_OUT), 32'h0);
    chk("simul_vld", 32'(BEN_VALID), 32'h0);
    chk("simul_nzp", 32'(NZP_OUT), 32'h1);

    // PSR restore
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 3'b001, 3'b000);
    chk("psr_prio", 32'(NZP_OUT), 32'h1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 3'b011, 3'b000);
    chk("psr_bad", 32'(NZP_OUT), 32'h2);

    // Out-of-range context
    ldcc(2'd3, 16'h8000, 1'b0); chk("oor_nzp", 32'(NZP_OUT), 32'h0);
    ldben(2'd3, 3'b111);
    chk("oor_ben", 32'(BEN_OUT), 32'h0);
    chk("oor_vld", 32'(BEN_VALID), 32'h1);
    idle(2'd0, 3'b000); chk("oor_nowrite", 32'(NZP_OUT), 32'h2);

    // BEN hold and mask extremes
    ldben(2'd0, 3'b000); chk("ir000", 32'(BEN_OUT), 32'h0);
    ldben(2'd0, 3'b111); chk("ir111", 32'(BEN_OUT), 32'h1);
    idle(2'd0, 3'b000);
    idle(2'd1, 3'b000); chk("ben_hold", 32'(BEN_OUT), 32'h1);

    // Statistics saturation and clear
    ldcc(2'd0, 16'h0001, 1'b0);
    for (int i = 0; i < 20; i++) ldben(2'd0, 3'b111);
`ifdef BRANCH_STATS_EN
    chk("eval_sat", 32'(BR_EVAL_CNT), 32'hF);
    chk("taken_sat", 32'(BR_TAKEN_CNT), 32'hF);
`else
    chk("eval_tied", 32'(BR_EVAL_CNT), 32'h0);
`endif
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 2'd0, 3'b000, 3'b111);
    chk("clr_eval", 32'(BR_EVAL_CNT), 32'h0);
    chk("clr_taken", 32'(BR_TAKEN_CNT), 32'h0);

    // Mid-sequence reset overriding a load
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 2'd1, 3'b000, 3'b111);
    chk("mid_rst_nzp", 32'(NZP_OUT), 32'h2);
    chk("mid_rst_ben", 32'(BEN_OUT), 32'h0);
    chk("mid_rst_init", 32'(CC_INIT), 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 40) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), 1'($urandom),
           2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
